// File: rtl/mp_register_file.sv
// Multi-read-port register file with byte-enable writes, optional read
// registering/bypass, and a one-entry-per-cycle clear engine.
module mp_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter int RD_REG     = 0,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         clr_req,
  output logic                         clr_busy,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_drop,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    drop_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   wmask;
  logic                    busy;
  logic                    wr_ok;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++)
      wmask[8*i +: 8] = {8{wr_be[i]}};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= wr_en & busy;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    wr_ok    = wr_en & ~busy;
    clr_busy = busy;
    wr_drop  = drop_q;
  end

  // Clear engine and write port share the array; they never overlap in time.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (busy) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= (mem_q[wr_addr] & ~wmask) | (wr_data & wmask);
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] stored;
    logic [DATA_WIDTH-1:0] rval;
    logic                  hit;

    always_comb begin
      ra     = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      stored = mem_q[ra];
      hit    = (BYPASS != 0) && wr_ok && (wr_addr == ra);
      if (busy)
        rval = '0;
      else if (hit)
        rval = (stored & ~wmask) | (wr_data & wmask);
      else
        rval = stored;
    end

    if (RD_REG != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] rdat_q;
      logic                  rvld_q;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          rdat_q <= '0;
          rvld_q <= 1'b0;
        end else begin
          rvld_q <= rd_en[p] & ~busy;
          if (rd_en[p])
            rdat_q <= rval;
        end
      end

      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rdat_q;
      assign rd_valid[p] = rvld_q;
    end else begin : g_comb
      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rval;
      assign rd_valid[p] = rd_en[p] & ~busy;
    end
  end

endmodule

// File: tb/tb_mp_register_file.sv
// Bench: a combinational/bypass instance and a registered/no-bypass
// instance share stimulus and are checked against an array model.
module tb_mp_register_file;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [7:0]  rd_addr = '0;

  logic        a_busy, a_drop, b_busy, b_drop;
  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_valid, b_rd_valid;

  mp_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2),
    .RD_REG(0), .BYPASS(1)) u_dut (
    .clk(clk), .arst_n(arst_n), .clr_req(clr_req), .clr_busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_drop(a_drop), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid));

  mp_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2),
    .RD_REG(1), .BYPASS(0)) u_reg (
    .clk(clk), .arst_n(arst_n), .clr_req(clr_req), .clr_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_drop(b_drop), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_busy;
  logic        m_drop;
  logic [31:0] m_rq [2];
  logic [1:0]  m_rv;

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] d, logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 0;
    m_drop = 1'b0;
    m_rq[0] = '0;
    m_rq[1] = '0;
    m_rv = '0;
  endtask

  function automatic logic [31:0] exp_comb(int p);
    logic [3:0] a = rd_addr[p*4 +: 4];
    if (m_busy > 0) return '0;
    if (wr_en && wr_addr == a) return merge(m_mem[a], wr_data, wr_be);
    return m_mem[a];
  endfunction

  task automatic compare_all();
    logic ib = (m_busy > 0);
    chk("a_rd_data", a_rd_data, {exp_comb(1), exp_comb(0)});
    chk("a_rd_valid", a_rd_valid, rd_en & {2{~ib}});
    chk("a_busy", a_busy, ib);
    chk("a_drop", a_drop, m_drop);
    chk("b_rd_data", b_rd_data, {m_rq[1], m_rq[0]});
    chk("b_rd_valid", b_rd_valid, m_rv);
    chk("b_busy", b_busy, ib);
    chk("b_drop", b_drop, m_drop);
  endtask

  // Clearing is modelled as wiping the whole array at once: while busy,
  // reads are forced to zero and writes are dropped, so it is unobservable.
  task automatic model_edge();
    logic ib = (m_busy > 0);
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) m_rq[p] = ib ? 32'h0 : m_mem[rd_addr[p*4 +: 4]];
      m_rv[p] = rd_en[p] & ~ib;
    end
    m_drop = wr_en & ib;
    if (!ib && wr_en) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
    if (ib) m_busy--;
    else if (clr_req) begin
      m_busy = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (arst_n) model_edge();
    #1;
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    chk("rst_a_data", a_rd_data, 64'h0);
    chk("rst_b_data", b_rd_data, 64'h0);
    chk("rst_busy", a_busy, 1'b0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
    rd_en = 2'b01; rd_addr = 8'h03;
    #1;
    chk("t1_rd0", a_rd_data[31:0], 64'hDEADBEEF);
    chk("t1_vld", a_rd_valid[0], 1'b1);
    step();

    wr_data = 32'h11223344; wr_be = 4'b0101;
    rd_en = 2'b11; rd_addr = 8'h33;
    #1;
    chk("t2_bypass", a_rd_data[63:32], 64'hDE22BE44);
    step();
    chk("t2_nobypass", b_rd_data[63:32], 64'hDEADBEEF);

    wr_en = 1'b0; rd_addr = 8'h53;
    step();
    chk("t3_regdata", b_rd_data, 64'h00000000_DE22BE44);
    chk("t3_regvld", b_rd_valid, 2'b11);
    rd_en = 2'b00;
    step();
    chk("t3_hold", b_rd_data, 64'h00000000_DE22BE44);
    chk("t3_vld0", b_rd_valid, 2'b00);

    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_be = 4'hF;
      wr_data = 32'hC0DE0000 + 32'(i);
      rd_en = 2'b11; rd_addr = {4'(15 - i), 4'(i)};
      step();
    end
    wr_en = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && a_busy; i++) begin
      wr_en = (i == 5); wr_addr = 4'd2; wr_data = 32'hFFFFFFFF;
      n++;
      step();
    end
    chk("t4_busy_len", 64'(n), 64'd16);
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = {4'(15 - i), 4'(i)};
      #1;
      chk("t4_zero", a_rd_data, 64'h0);
      step();
    end

    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5A5A5;
    step();
    clr_req = 1'b0; wr_en = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && a_busy; i++) begin
      clr_req = (i == 3);
      n++;
      step();
    end
    clr_req = 1'b0;
    chk("t5_busy_len", 64'(n), 64'd16);
    rd_addr = 8'h77;
    #1;
    chk("t5_addr7", a_rd_data, 64'h0);
    step();

    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h0BADF00D;
    step();
    wr_en = 1'b0; rd_addr = 8'h99;
    step();
    rd_en = 2'b00; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1;
    arst_n = 1'b0;
    #1;
    chk("t6_busy", a_busy, 1'b0);
    chk("t6_a_data", a_rd_data, 64'h0);
    chk("t6_b_data", b_rd_data, 64'h0);
    model_reset();
    step();
    #2;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 4'd9; wr_be = 4'hF; wr_data = 32'h12345678;
    rd_en = 2'b11; rd_addr = 8'h99;
    #1;
    chk("t6_rw", a_rd_data, 64'h12345678_12345678);
    step();
    wr_en = 1'b0;
    step();

    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_be   = 4'($urandom);
      wr_data = $urandom;
      rd_en   = 2'($urandom);
      rd_addr = 8'($urandom);
      clr_req = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
